internal_framebuffer_streamer: RTL and testbench

Read-side sequencer and output buffer for the internal framebuffer. On a start command it sweeps a linear pixel range and issues one read address per cycle to the internal framebuffer reader stage. The reader has no backpressure and returns data on `rvalid`/`rlast`/`rdata`; this block collects that data in a FIFO and presents it as an AXI-Stream master. Credit-based issue ensures the FIFO never overflows.

---
 rtl/internal_framebuffer_streamer.sv | 193 +++++++++++++++++++
 tb/tb_internal_framebuffer_streamer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/internal_framebuffer_streamer.sv
// Framebuffer read sequencer with credit-limited issue and AXI-Stream output buffer.
// Optional sticky overflow check: define RASTERIX_FB_STREAMER_OVERFLOW_CHECK_EN.

// Generic show-ahead FIFO: head visible whenever not empty.
// Latency: write at edge N is visible at the head in cycle N+1.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module internal_framebuffer_streamer_fifo #(
    parameter int WIDTH    = 33,
    parameter int DEPTH_LG = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 2 ** DEPTH_LG;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LG-1:0] wr_ptr;
    logic [DEPTH_LG-1:0] rd_ptr;
    logic [DEPTH_LG:0]   cnt;
    logic                do_push;
    logic                do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (DEPTH_LG+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Drive zero rather than stale storage when nothing is held.
    assign rd_dat  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LG'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LG'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (DEPTH_LG+1)'(1);
                2'b01:   cnt <= cnt - (DEPTH_LG+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Sweeps a pixel range issuing one read per cycle, buffers reader data, streams it out.
// Latency: start to first request 1 cycle, start to first beat 4 cycles.
// Backpressure: issue stalls when credits (free FIFO slots) run out; resumes the cycle after a pop.
module internal_framebuffer_streamer #(
    parameter int NUMBER_OF_SUB_PIXELS         = 4,
    parameter int SUB_PIXEL_WIDTH              = 8,
    parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int FIFO_DEPTH_LG                = 3
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                start,
    input  logic [FRAMEBUFFER_SIZE_IN_PIXEL_LG-1:0]             startAddr,
    input  logic [FRAMEBUFFER_SIZE_IN_PIXEL_LG:0]               pixelCount,
    output logic                                                busy,
    output logic                                                arvalid,
    output logic                                                arlast,
    output logic [FRAMEBUFFER_SIZE_IN_PIXEL_LG-1:0]             araddr,
    input  logic                                                rvalid,
    input  logic                                                rlast,
    input  logic [NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH-1:0]     rdata,
    output logic                                                m_axis_tvalid,
    input  logic                                                m_axis_tready,
    output logic                                                m_axis_tlast,
    output logic [NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH-1:0]     m_axis_tdata,
    output logic                                                overflow
);
    localparam int ADDR_WIDTH  = FRAMEBUFFER_SIZE_IN_PIXEL_LG;
    localparam int PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH;
    localparam int FIFO_DEPTH  = 2 ** FIFO_DEPTH_LG;
    localparam int CW          = FIFO_DEPTH_LG + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [CW-1:0]         credits;
    logic [CW-1:0]         credits_next;
    logic                  pop;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PIXEL_WIDTH:0]  fifo_head;

    assign pop = m_axis_tvalid & m_axis_tready;
    // The request presented this cycle consumes a credit; a pop this cycle returns one.
    assign credits_next = credits - CW'(arvalid) + CW'(pop);
    assign fifo_push    = rvalid & (state != IDLE) & (~fifo_full | pop);

    internal_framebuffer_streamer_fifo #(
        .WIDTH    (PIXEL_WIDTH + 1),
        .DEPTH_LG (FIFO_DEPTH_LG)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifo_push),
        .wr_dat ({rlast, rdata}),
        .pop    (pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tlast  = fifo_head[PIXEL_WIDTH];
    assign m_axis_tdata  = fifo_head[PIXEL_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            arvalid   <= 1'b0;
            arlast    <= 1'b0;
            araddr    <= '0;
            addr      <= '0;
            remaining <= '0;
            credits   <= CW'(FIFO_DEPTH);
        end else begin
            credits <= credits_next;
            arvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && pixelCount != '0) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        arvalid   <= 1'b1;
                        araddr    <= startAddr;
                        arlast    <= (pixelCount == (ADDR_WIDTH+1)'(1));
                        addr      <= startAddr + ADDR_WIDTH'(1);
                        remaining <= pixelCount - (ADDR_WIDTH+1)'(1);
                    end
                end
                ISSUE: begin
                    if (arvalid && arlast) begin
                        state <= DRAIN;
                    end else if (remaining != '0 && credits_next != '0) begin
                        arvalid   <= 1'b1;
                        araddr    <= addr;
                        arlast    <= (remaining == (ADDR_WIDTH+1)'(1));
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
                    end
                end
                DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RASTERIX_FB_STREAMER_OVERFLOW_CHECK_EN
    logic overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (rvalid && state != IDLE && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_internal_framebuffer_streamer.sv
// Scoreboard bench for internal_framebuffer_streamer with a 2-cycle reader model.
module tb_internal_framebuffer_streamer;
    logic        clk;
    logic        reset;
    logic        start;
    logic [17:0] startAddr;
    logic [18:0] pixelCount;
    logic        busy;
    logic        arvalid;
    logic        arlast;
    logic [17:0] araddr;
    logic        rvalid;
    logic        rlast;
    logic [31:0] rdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        overflow;

`ifdef RASTERIX_FB_STREAMER_OVERFLOW_CHECK_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    internal_framebuffer_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .startAddr     (startAddr),
        .pixelCount    (pixelCount),
        .busy          (busy),
        .arvalid       (arvalid),
        .arlast        (arlast),
        .araddr        (araddr),
        .rvalid        (rvalid),
        .rlast         (rlast),
        .rdata         (rdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .overflow      (overflow)
    );

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [17:0] addr;
        logic        last;
    } req_t;

    beat_t exp_q[$];
    req_t  req_q[$];
    int    beat_cyc[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    t_start  = 0;
    int    beat_cnt = 0;
    int    inject_req  = 0;
    int    inject_done = 0;
    logic  last_prev = 1'b0;

    logic        d0_v, d1_v, d0_l, d1_l;
    logic [17:0] d0_a, d1_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reader model: response appears 2 cycles after the request; extra pulses on demand.
    initial begin
        d0_v = 0; d1_v = 0; d0_l = 0; d1_l = 0; d0_a = '0; d1_a = '0;
        rvalid = 0; rlast = 0; rdata = '0;
        forever begin
            @(negedge clk);
            rvalid = d1_v;
            rlast  = d1_l;
            rdata  = {14'b0, d1_a};
            d1_v = d0_v; d1_l = d0_l; d1_a = d0_a;
            d0_v = arvalid; d0_l = arlast; d0_a = araddr;
            if (inject_done < inject_req) begin
                rvalid = 1'b1;
                rlast  = 1'b0;
                rdata  = 32'hDEAD_BEEF;
                inject_done++;
            end
        end
    end

    // Monitor: logs requests, pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (last_prev) check("busy_after_last", {63'b0, busy}, 64'd0);
            last_prev = 1'b0;
            if (arvalid) req_q.push_back('{cyc, araddr, arlast});
            if (m_axis_tvalid && m_axis_tready) begin
                beat_t e;
                beat_cnt++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", {32'b0, m_axis_tdata}, {32'b0, e.data});
                    check("beat_last", {63'b0, m_axis_tlast}, {63'b0, e.last});
                end
                if (m_axis_tlast) begin
                    check("busy_at_last", {63'b0, busy}, 64'd1);
                    last_prev = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [17:0] a, input logic [18:0] n, input bit accept);
        @(posedge clk); #1;
        startAddr  = a;
        pixelCount = n;
        start      = 1'b1;
        if (accept) begin
            for (int i = 0; i < int'(n); i++) begin
                logic [17:0] aa;
                aa = a + 18'(i);
                exp_q.push_back('{(i == int'(n) - 1), {14'b0, aa}});
            end
        end
        @(posedge clk); #1;
        t_start = cyc;
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        check({name, "_idle_timeout"}, {63'b0, done}, 64'd1);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        m_axis_tready = r;
    endtask

    task automatic clear_logs();
        req_q.delete();
        beat_cyc.delete();
        beat_cnt = 0;
    endtask

    initial begin
        bit hit;
        reset = 1; start = 0; startAddr = '0; pixelCount = '0; m_axis_tready = 1;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 0);
        check("rst_arvalid", {63'b0, arvalid}, 0);
        check("rst_arlast", {63'b0, arlast}, 0);
        check("rst_araddr", {46'b0, araddr}, 0);
        check("rst_tvalid", {63'b0, m_axis_tvalid}, 0);
        check("rst_tdata_tlast", {31'b0, m_axis_tlast, m_axis_tdata}, 0);
        check("rst_overflow", {63'b0, overflow}, 0);
        @(posedge clk); #1 reset = 0;

        // 1: basic 8-pixel sweep, full rate
        clear_logs();
        issue(18'h10, 19'd8, 1);
        @(negedge clk);
        check("t1_busy_start", {63'b0, busy}, 1);
        check("t1_first_araddr", {46'b0, araddr}, 64'h10);
        wait_idle("t1");
        check("t1_req_count", req_q.size(), 8);
        for (int i = 0; i < req_q.size() && i < 8; i++) begin
            check("t1_req_addr", {46'b0, req_q[i].addr}, 64'h10 + 64'(i));
            check("t1_req_last", {63'b0, req_q[i].last}, {63'b0, (i == 7)});
            check("t1_req_cyc", req_q[i].cyc, t_start + i);
        end
        check("t1_beat_count", beat_cyc.size(), 8);
        for (int i = 0; i < beat_cyc.size() && i < 8; i++)
            check("t1_beat_cyc", beat_cyc[i], t_start + 3 + i);

        // 2: backpressure holds issue at FIFO depth
        clear_logs();
        set_ready(0);
        issue(18'h100, 19'd20, 1);
        repeat (30) @(negedge clk);
        check("t2_req_stall", req_q.size(), 8);
        check("t2_arvalid_low", {63'b0, arvalid}, 0);
        check("t2_tvalid_held", {63'b0, m_axis_tvalid}, 1);
        set_ready(1);
        wait_idle("t2");
        check("t2_req_total", req_q.size(), 20);
        check("t2_beats", beat_cnt, 20);
        check("t2_scoreboard_empty", exp_q.size(), 0);
        check("t2_overflow", {63'b0, overflow}, 0);

        // 3: address wrap
        clear_logs();
        issue(18'h3FFFE, 19'd4, 1);
        wait_idle("t3");
        check("t3_req_count", req_q.size(), 4);
        if (req_q.size() == 4) begin
            check("t3_addr0", {46'b0, req_q[0].addr}, 64'h3FFFE);
            check("t3_addr1", {46'b0, req_q[1].addr}, 64'h3FFFF);
            check("t3_addr2", {46'b0, req_q[2].addr}, 64'h00000);
            check("t3_addr3", {46'b0, req_q[3].addr}, 64'h00001);
        end

        // 4: zero-length command and start while busy
        clear_logs();
        issue(18'h0, 19'd0, 0);
        @(negedge clk);
        check("t4_zero_busy", {63'b0, busy}, 0);
        repeat (10) @(negedge clk);
        check("t4_zero_req", req_q.size(), 0);
        check("t4_zero_beats", beat_cnt, 0);
        issue(18'h200, 19'd4, 1);
        issue(18'h300, 19'd5, 0);
        wait_idle("t4");
        repeat (5) @(negedge clk);
        check("t4_req_count", req_q.size(), 4);
        if (req_q.size() == 4) check("t4_last_addr", {46'b0, req_q[3].addr}, 64'h203);
        check("t4_beats", beat_cnt, 4);

        // 5: reset mid-stream, then stale responses
        clear_logs();
        issue(18'h400, 19'd8, 1);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #1;
            if (beat_cnt >= 3) hit = 1;
        end
        check("t5_three_beats_seen", {63'b0, hit}, 1);
        reset = 1;
        exp_q.delete();
        @(negedge clk);
        check("t5_rst_busy", {63'b0, busy}, 0);
        check("t5_rst_arvalid", {63'b0, arvalid}, 0);
        check("t5_rst_tvalid", {63'b0, m_axis_tvalid}, 0);
        check("t5_rst_tdata", {32'b0, m_axis_tdata}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        inject_req = inject_req + 3;
        repeat (8) @(negedge clk);
        check("t5_stale_tvalid", {63'b0, m_axis_tvalid}, 0);
        check("t5_stale_busy", {63'b0, busy}, 0);
        check("t5_beats_after_reset", beat_cnt, 3);
        issue(18'h500, 19'd4, 1);
        wait_idle("t5");
        check("t5_new_beats", beat_cnt, 7);
        check("t5_scoreboard_empty", exp_q.size(), 0);

        // 6: extra response with FIFO full
        clear_logs();
        set_ready(0);
        issue(18'h600, 19'd20, 1);
        repeat (20) @(negedge clk);
        check("t6_fifo_full_tvalid", {63'b0, m_axis_tvalid}, 1);
        @(posedge clk); #1;
        inject_req = inject_req + 1;
        repeat (3) @(negedge clk);
        check("t6_overflow", {63'b0, overflow}, {63'b0, EXP_OVF});
        set_ready(1);
        wait_idle("t6");
        check("t6_beats", beat_cnt, 20);
        check("t6_scoreboard_empty", exp_q.size(), 0);
        check("t6_overflow_sticky", {63'b0, overflow}, {63'b0, EXP_OVF});
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        check("t6_overflow_cleared", {63'b0, overflow}, 0);
        @(posedge clk); #1 reset = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
